// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter
//   Round-robin arbiter for the shared AHB bus in front of the AHB-to-APB
//   bridge. It follows the owner's Htrans/Hburst to find transfer and burst
//   boundaries, re-arbitrates only at those boundaries while Hreadyout is high,
//   and parks the bus on DEFAULT_MASTER when nobody requests.
//   Optional feature macro: ARB_LOCK_EN (adds Hlock, enables locked tenures).
// Ports
//   Hclk, Hreset       clock / asynchronous active-high reset
//   Hbusreq            per-master bus request
//   Hlock              per-master lock request (ARB_LOCK_EN only)
//   Htrans, Hburst     muxed transfer type / burst type of the current owner
//   Hreadyout          slave ready; low freezes every piece of arbiter state
//   Hgrant             one-hot grant
//   Hmaster            address-phase owner index
//   Hmaster_data       data-phase owner index (Hmaster delayed one ready edge)
//   Hmastlock          current transfer is locked (constant 0 without ARB_LOCK_EN)
module ahb_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned MASTER_W       = 2,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                   Hclk,
  input  logic                   Hreset,
  input  logic [NUM_MASTERS-1:0] Hbusreq,
`ifdef ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0] Hlock,
`endif
  input  logic [1:0]             Htrans,
  input  logic [2:0]             Hburst,
  input  logic                   Hreadyout,
  output logic [NUM_MASTERS-1:0] Hgrant,
  output logic [MASTER_W-1:0]    Hmaster,
  output logic [MASTER_W-1:0]    Hmaster_data,
  output logic                   Hmastlock
);

  typedef enum logic [1:0] {ST_PARK, ST_OWN, ST_BURST} state_e;

  localparam logic [MASTER_W-1:0]    DEF_IDX   = MASTER_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [MASTER_W-1:0]    hmaster_q, hmaster_d;
  logic [MASTER_W-1:0]    hmaster_data_q, hmaster_data_d;
  logic [MASTER_W-1:0]    last_idx_q, last_idx_d;
  logic [4:0]             beats_left_q, beats_left_d;

  logic                   is_idle, is_nonseq, is_seq, fixed_burst, single_burst, incr_burst;
  logic                   owner_req, owner_locked, any_req, boundary, found;
  logic [4:0]             burst_beats_m1;
  logic [NUM_MASTERS-1:0] owner_shift, scan;
  logic [MASTER_W-1:0]    winner;
  int unsigned            idx;

  // Transfer decode and boundary detection
  always_comb begin
    is_idle      = (Htrans == 2'b00);
    is_nonseq    = (Htrans == 2'b10);
    is_seq       = (Htrans == 2'b11);
    single_burst = (Hburst == 3'b000);
    incr_burst   = (Hburst == 3'b001);
    fixed_burst  = |Hburst[2:1];
    case (Hburst[2:1])
      2'b01:   burst_beats_m1 = 5'd3;
      2'b10:   burst_beats_m1 = 5'd7;
      2'b11:   burst_beats_m1 = 5'd15;
      default: burst_beats_m1 = 5'd0;
    endcase
    owner_shift = Hbusreq >> hmaster_q;
    owner_req   = owner_shift[0];
    any_req     = |Hbusreq;
    boundary    = is_idle
               || (is_nonseq && single_burst)
               || (is_seq && fixed_burst && (beats_left_q == 5'd1))
               || ((is_nonseq || is_seq) && incr_burst && !owner_req);
  end

`ifdef ARB_LOCK_EN
  logic [NUM_MASTERS-1:0] lock_shift;
  logic                   hmastlock_q, hmastlock_d;

  always_comb begin
    lock_shift   = Hlock >> hmaster_q;
    owner_locked = lock_shift[0];
    hmastlock_d  = Hreadyout ? owner_locked : hmastlock_q;
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) hmastlock_q <= 1'b0;
    else        hmastlock_q <= hmastlock_d;
  end

  assign Hmastlock = hmastlock_q;
`else
  assign owner_locked = 1'b0;
  assign Hmastlock    = 1'b0;
`endif

  // Round-robin scan starting just after the last winner; the last winner is
  // reached only after every other master, so it keeps the bus only when alone.
  always_comb begin
    winner = DEF_IDX;
    found  = 1'b0;
    idx    = 0;
    scan   = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      idx  = (32'(last_idx_q) + k) % NUM_MASTERS;
      scan = Hbusreq >> idx;
      if (!found && scan[0]) begin
        winner = MASTER_W'(idx);
        found  = 1'b1;
      end
    end
    if (owner_locked) winner = hmaster_q;
  end

  // Re-arbitration happens only at a boundary: a NONSEQ opening a fixed burst,
  // INCR with the owner still requesting, or BUSY all keep the current owner.
  always_comb begin
    state_d        = state_q;
    hgrant_d       = hgrant_q;
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    last_idx_d     = last_idx_q;
    beats_left_d   = beats_left_q;
    if (Hreadyout) begin
      hmaster_data_d = hmaster_q;
      if (is_nonseq)
        beats_left_d = fixed_burst ? burst_beats_m1 : '0;
      else if (is_seq && (beats_left_q != '0))
        beats_left_d = beats_left_q - 5'd1;

      if (boundary) begin
        hmaster_d  = winner;
        last_idx_d = winner;
        hgrant_d   = NUM_MASTERS'(1) << winner;
        state_d    = any_req ? ST_OWN : ST_PARK;
      end else if (is_nonseq && fixed_burst) begin
        state_d = ST_BURST;
      end else if (state_q != ST_BURST) begin
        state_d = any_req ? ST_OWN : ST_PARK;
      end
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q        <= ST_PARK;
      hgrant_q       <= DEF_GRANT;
      hmaster_q      <= DEF_IDX;
      hmaster_data_q <= DEF_IDX;
      last_idx_q     <= DEF_IDX;
      beats_left_q   <= '0;
    end else begin
      state_q        <= state_d;
      hgrant_q       <= hgrant_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      last_idx_q     <= last_idx_d;
      beats_left_q   <= beats_left_d;
    end
  end

  assign Hgrant       = hgrant_q;
  assign Hmaster      = hmaster_q;
  assign Hmaster_data = hmaster_data_q;

endmodule
